mac_sequencer: RTL and testbench
================================

MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 SHALL provide parameter TERMS, default 16, number of products accumulated per dot product (legal range 1..1024).
REQ-002 SHALL provide parameter MAC_LAT, default 3, clock cycles from mac_a/mac_b/mac_c driven to mac_p valid at the external DSP48 MAC (legal range 1..8).
REQ-003 SHALL provide port clock, input, 1, single clock; all logic on rising edge.
REQ-004 SHALL provide port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL provide port start, input, 1, one-cycle request to begin a dot product.
REQ-006 SHALL provide port busy, output, 1, high from accepted start until result handshake completes.
REQ-007 SHALL provide ports in_valid (input, 1), in_ready (output, 1), a_in (input, 18, signed pixel), b_in (input, 18, signed weight), forming the operand stream.
REQ-008 SHALL provide ports mac_a (output, 18), mac_b (output, 18), mac_c (output, 48) and mac_p (input, 48), connecting to the DSP48 MAC computing p = a*b + c.
REQ-009 SHALL provide ports result (output, 48), result_valid (output, 1) and result_ready (input, 1), forming the output stream.

Function
REQ-010 SHALL implement states IDLE, ISSUE, WAIT, DONE.
REQ-011 In IDLE, start=1 SHALL clear the term counter, load acc with 0 (or bias, see REQ-022), and enter ISSUE on the next cycle; start in any other state SHALL be ignored.
REQ-012 In ISSUE, in_ready SHALL be 1; in all other states in_ready SHALL be 0.
REQ-013 On in_valid & in_ready, the block SHALL register mac_a=a_in, mac_b=b_in, mac_c=acc, and enter WAIT; ISSUE with in_valid=0 SHALL hold state indefinitely.
REQ-014 WAIT SHALL last exactly MAC_LAT cycles; on its final cycle acc SHALL capture mac_p and the term counter SHALL increment.
REQ-015 After capture, the block SHALL enter DONE if the counter equals TERMS, else ISSUE; peak throughput is one term per MAC_LAT+1 cycles.
REQ-016 mac_a, mac_b and mac_c SHALL hold their values throughout WAIT.
REQ-017 In DONE, result SHALL equal acc and result_valid SHALL be 1; result and result_valid SHALL hold until result_ready=1.
REQ-018 In DONE, result_ready=1 SHALL return the block to IDLE on the next cycle, with result_valid=0; start in that same cycle SHALL be ignored.
REQ-019 Accumulation SHALL wrap modulo 2^48 as produced by the MAC; the block performs no arithmetic on mac_p.

Reset
REQ-020 On reset=1, regardless of clock or current state, the block SHALL enter IDLE with busy=0, in_ready=0, result_valid=0, result=0, mac_a=0, mac_b=0, mac_c=0, acc=0, counter=0.
REQ-021 Reset mid-operation SHALL abandon the partial sum; no result SHALL be emitted for it.

Configuration
REQ-022 With macro MAC_SEQ_BIAS_EN defined, the block SHALL add port bias (input, 48) sampled on accepted start as the initial acc; without it, the port SHALL be absent and the initial acc SHALL be 0.

Verification
REQ-023 TERMS=4, MAC_LAT=3: start, then operands (1,2),(3,4),(5,6),(7,8) presented with in_valid held -> result=100, result_valid 16 cycles after the first accepted operand.
REQ-024 Negative operands (-3,5),(2,-7), TERMS=2 -> result=-29 sign-extended to 48 bits (0xFFFF_FFFF_FFE3).
REQ-025 in_valid deasserted for 5 cycles between terms -> state holds in ISSUE, final result unchanged, busy stays 1.
REQ-026 result_ready held 0 for 10 cycles in DONE, with start pulsed -> result and result_valid stable; start ignored; IDLE follows result_ready=1.
REQ-027 reset pulsed during WAIT of term 2 -> all outputs zero immediately; a subsequent start and full TERMS=4 run produces the correct fresh sum.
REQ-028 With MAC_SEQ_BIAS_EN defined, bias=1000, operands as in REQ-023 -> result=1100.

Source files
------------

// File: rtl/mac_sequencer.sv
// Sequences one dot product through an external DSP48 MAC (p = a*b + c), one term at a time.
// Optional: define MAC_SEQ_BIAS_EN to add a 48-bit bias port that seeds the accumulator on start.
module mac_sequencer #(
    parameter int TERMS   = 16,
    parameter int MAC_LAT = 3
) (
    input  logic        clock,
    input  logic        reset,
`ifdef MAC_SEQ_BIAS_EN
    input  logic [47:0] bias,
`endif
    input  logic        start,
    output logic        busy,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [17:0] a_in,
    input  logic [17:0] b_in,
    output logic [17:0] mac_a,
    output logic [17:0] mac_b,
    output logic [47:0] mac_c,
    input  logic [47:0] mac_p,
    output logic [47:0] result,
    output logic        result_valid,
    input  logic        result_ready
);

    // state | meaning
    // IDLE  | waiting for start
    // ISSUE | in_ready high, waiting for an operand pair
    // WAIT  | operands held on the MAC until its product is valid
    // DONE  | result presented until result_ready
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int CNT_W  = $clog2(TERMS + 1);
    localparam int WAIT_W = 4;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [47:0]       acc_q, acc_d;
    logic [17:0]       mac_a_q, mac_a_d;
    logic [17:0]       mac_b_q, mac_b_d;
    logic [47:0]       mac_c_q, mac_c_d;
    logic [47:0]       acc_init;

`ifdef MAC_SEQ_BIAS_EN
    assign acc_init = bias;
`else
    assign acc_init = '0;
`endif

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        acc_d   = acc_q;
        mac_a_d = mac_a_q;
        mac_b_d = mac_b_q;
        mac_c_d = mac_c_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d   = '0;
                    acc_d   = acc_init;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (in_valid) begin
                    mac_a_d = a_in;
                    mac_b_d = b_in;
                    mac_c_d = acc_q;
                    wait_d  = WAIT_W'(MAC_LAT - 1);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // Down-counter terminal count marks the cycle mac_p is valid
                if (wait_q == '0) begin
                    acc_d   = mac_p;
                    cnt_d   = cnt_inc;
                    state_d = (cnt_inc == CNT_W'(TERMS)) ? S_DONE : S_ISSUE;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            S_DONE: begin
                if (result_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wait_q  <= '0;
            acc_q   <= '0;
            mac_a_q <= '0;
            mac_b_q <= '0;
            mac_c_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            acc_q   <= acc_d;
            mac_a_q <= mac_a_d;
            mac_b_q <= mac_b_d;
            mac_c_q <= mac_c_d;
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign in_ready     = (state_q == S_ISSUE);
    assign result_valid = (state_q == S_DONE);
    assign result       = acc_q;
    assign mac_a        = mac_a_q;
    assign mac_b        = mac_b_q;
    assign mac_c        = mac_c_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer (TERMS=4, MAC_LAT=3) with a behavioural DSP48 model and a
// sum-of-products reference; covers MAC_SEQ_BIAS_EN when the macro is defined.
module tb_mac_sequencer;

    localparam int TERMS   = 4;
    localparam int MAC_LAT = 3;
    localparam int TAP     = (MAC_LAT > 1) ? MAC_LAT - 2 : 0;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        result_ready = 1'b0;
    logic [17:0] a_in = '0;
    logic [17:0] b_in = '0;
    logic        busy, in_ready, result_valid;
    logic [17:0] mac_a, mac_b;
    logic [47:0] mac_c, mac_p, result;
    logic [47:0] bias_val = '0;
`ifdef MAC_SEQ_BIAS_EN
    logic [47:0] bias;
    assign bias = bias_val;
`endif

    int     tests_run = 0;
    int     tests_failed = 0;
    int     cyc = 0;
    int     acc_cyc = 0;
    longint ref_acc = 0;

    mac_sequencer #(.TERMS(TERMS), .MAC_LAT(MAC_LAT)) u_dut (
        .clock(clock),
        .reset(reset),
`ifdef MAC_SEQ_BIAS_EN
        .bias(bias),
`endif
        .start(start),
        .busy(busy),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a_in(a_in),
        .b_in(b_in),
        .mac_a(mac_a),
        .mac_b(mac_b),
        .mac_c(mac_c),
        .mac_p(mac_p),
        .result(result),
        .result_valid(result_valid),
        .result_ready(result_ready)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // DSP48 model: product valid MAC_LAT cycles after its operands are driven
    logic signed [47:0] sa, sb;
    logic [47:0] p_comb;
    logic [47:0] dly [0:7];
    assign sa = {{30{mac_a[17]}}, mac_a};
    assign sb = {{30{mac_b[17]}}, mac_b};
    assign p_comb = sa * sb + mac_c;
    always @(posedge clock) begin
        dly[0] <= p_comb;
        for (int k = 1; k < 8; k++) dly[k] <= dly[k-1];
    end
    assign mac_p = (MAC_LAT == 1) ? p_comb : dly[TAP];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_dot();
        start = 1'b1;
        tick();
        start = 1'b0;
`ifdef MAC_SEQ_BIAS_EN
        ref_acc = longint'(bias_val);
`else
        ref_acc = 0;
`endif
    endtask

    task automatic send_term(input logic signed [17:0] a, input logic signed [17:0] b);
        bit ok;
        int n;
        logic [47:0] c_exp;
        ok = 1'b0;
        n = 0;
        a_in = a;
        b_in = b;
        in_valid = 1'b1;
        while (!ok && n < 200) begin
            ok = in_ready;
            if (ok) acc_cyc = cyc;
            tick();
            n++;
        end
        in_valid = 1'b0;
        c_exp = ref_acc[47:0];
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL send_term: in_ready never seen within 200 cycles");
        end else if (mac_a !== a || mac_b !== b || mac_c !== c_exp) begin
            tests_failed++;
            $display("FAIL mac_issue: got a=%h b=%h c=%h, want a=%h b=%h c=%h",
                     mac_a, mac_b, mac_c, a, b, c_exp);
        end
        for (int i = 1; i < MAC_LAT; i++) begin
            tick();
            tests_run++;
            if (mac_a !== a || mac_b !== b || mac_c !== c_exp || in_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL mac_hold: got a=%h b=%h c=%h rdy=%b, want a=%h b=%h c=%h rdy=0",
                         mac_a, mac_b, mac_c, in_ready, a, b, c_exp);
            end
        end
        ref_acc += longint'(a) * longint'(b);
    endtask

    task automatic wait_result(output bit ok);
        int n;
        n = 0;
        while (result_valid !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        ok = (result_valid === 1'b1);
        if (!ok) begin
            tests_run++;
            tests_failed++;
            $display("FAIL wait_result: result_valid not seen within 200 cycles");
        end
    endtask

    task automatic handshake();
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        tests_run++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || result_valid !== 1'b0 || result !== 48'd0 ||
            mac_a !== 18'd0 || mac_b !== 18'd0 || mac_c !== 48'd0) begin
            tests_failed++;
            $display("FAIL reset_state: busy=%b rdy=%b rv=%b res=%h a=%h b=%h c=%h, want all 0",
                     busy, in_ready, result_valid, result, mac_a, mac_b, mac_c);
        end
        #2 reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        bit ok;
        int first;
        logic [47:0] want;
`ifdef MAC_SEQ_BIAS_EN
        bias_val = 48'd1000;
        want = 48'd1100;
`else
        want = 48'd100;
`endif
        start_dot();
        tests_run++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL start_accept: busy=%b in_ready=%b, want 1 1", busy, in_ready);
        end
        send_term(18'sd1, 18'sd2);
        first = acc_cyc;
        send_term(18'sd3, 18'sd4);
        send_term(18'sd5, 18'sd6);
        send_term(18'sd7, 18'sd8);
        wait_result(ok);
        if (ok) begin
            tests_run++;
            if (cyc - first != 16) begin
                tests_failed++;
                $display("FAIL basic_latency: result_valid after %0d cycles, want 16", cyc - first);
            end
            tests_run++;
            if (result !== want || result !== ref_acc[47:0]) begin
                tests_failed++;
                $display("FAIL basic_result: got %0d, want %0d", result, want);
            end
        end
        handshake();
        tests_run++;
        if (busy !== 1'b0 || result_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_idle: busy=%b rv=%b, want 0 0", busy, result_valid);
        end
        bias_val = '0;
    endtask

    task automatic test_negative();
        bit ok;
        start_dot();
        send_term(-18'sd3, 18'sd5);
        send_term(18'sd2, -18'sd7);
        send_term(18'sd0, 18'sd0);
        send_term(18'sd0, 18'sd0);
        wait_result(ok);
        if (ok) begin
            tests_run++;
            if (result !== 48'hFFFF_FFFF_FFE3) begin
                tests_failed++;
                $display("FAIL negative_result: got %h, want ffffffffffe3", result);
            end
        end
        handshake();
    endtask

    task automatic test_stall();
        bit ok;
        int n;
        start_dot();
        for (int t = 0; t < TERMS; t++) begin
            if (t != 0) begin
                n = 0;
                while (in_ready !== 1'b1 && n < 50) begin
                    tick();
                    n++;
                end
                for (int g = 0; g < 5; g++) begin
                    tests_run++;
                    if (in_ready !== 1'b1 || busy !== 1'b1) begin
                        tests_failed++;
                        $display("FAIL stall_hold: in_ready=%b busy=%b, want 1 1", in_ready, busy);
                    end
                    tick();
                end
            end
            send_term(18'($urandom), 18'($urandom));
        end
        wait_result(ok);
        if (ok) begin
            tests_run++;
            if (result !== ref_acc[47:0]) begin
                tests_failed++;
                $display("FAIL stall_result: got %h, want %h", result, ref_acc[47:0]);
            end
        end
        handshake();
    endtask

    task automatic test_hold_done();
        bit ok;
        logic [47:0] want;
        start_dot();
        for (int t = 0; t < TERMS; t++) send_term(18'($urandom), 18'($urandom));
        want = ref_acc[47:0];
        wait_result(ok);
        for (int i = 0; i < 10; i++) begin
            start = (i == 3);
            tests_run++;
            if (result !== want || result_valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL done_hold: res=%h rv=%b, want %h 1", result, result_valid, want);
            end
            tick();
        end
        start = 1'b1;
        result_ready = 1'b1;
        tick();
        start = 1'b0;
        result_ready = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || result_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL done_release: busy=%b rv=%b, want 0 0", busy, result_valid);
        end
        tick();
        tests_run++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL done_start_ignored: busy=%b in_ready=%b, want 0 0", busy, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        start_dot();
        send_term(18'sd11, 18'sd13);
        send_term(18'sd17, 18'sd19);
        #1 reset = 1'b1;
        #1;
        tests_run++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || result_valid !== 1'b0 || result !== 48'd0 ||
            mac_a !== 18'd0 || mac_b !== 18'd0 || mac_c !== 48'd0) begin
            tests_failed++;
            $display("FAIL reset_mid: busy=%b rdy=%b rv=%b res=%h a=%h b=%h c=%h, want all 0",
                     busy, in_ready, result_valid, result, mac_a, mac_b, mac_c);
        end
        #1 reset = 1'b0;
        tick();
        tests_run++;
        if (result_valid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_idle: rv=%b busy=%b, want 0 0", result_valid, busy);
        end
        start_dot();
        send_term(18'sd2, 18'sd3);
        send_term(-18'sd4, 18'sd5);
        send_term(18'sd6, -18'sd7);
        send_term(18'sd8, 18'sd9);
        wait_result(ok);
        if (ok) begin
            tests_run++;
            if (result !== ref_acc[47:0]) begin
                tests_failed++;
                $display("FAIL reset_mid_fresh: got %h, want %h", result, ref_acc[47:0]);
            end
        end
        handshake();
    endtask

    task automatic test_random();
        bit ok;
        int gap;
        for (int r = 0; r < 6; r++) begin
`ifdef MAC_SEQ_BIAS_EN
            bias_val = {16'($urandom), 32'($urandom)};
`endif
            start_dot();
            for (int t = 0; t < TERMS; t++) begin
                gap = int'($urandom_range(0, 3));
                for (int g = 0; g < gap; g++) tick();
                send_term(18'($urandom), 18'($urandom));
            end
            wait_result(ok);
            if (ok) begin
                tests_run++;
                if (result !== ref_acc[47:0]) begin
                    tests_failed++;
                    $display("FAIL random_result[%0d]: got %h, want %h", r, result, ref_acc[47:0]);
                end
            end
            handshake();
        end
        bias_val = '0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_stall();
        test_hold_done();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
